// File: rtl/rob_ctrl.sv
// rob_ctrl: 4-entry in-order reorder-buffer controller driving RAT rename updates and ARF commits.
// Optional synchronous flush (i_flush) is compiled in with `define ROB_FLUSH_EN.
module rob_ctrl #(
    parameter int TAG_W  = 2,
    parameter int DEPTH  = 4,
    parameter int ARCH_W = 2,
    parameter int DATA_W = 16
) (
    input  logic              i_clk,
    input  logic              i_rstn,
`ifdef ROB_FLUSH_EN
    input  logic              i_flush,
`endif
    input  logic              i_disp_valid,
    output logic              o_disp_ready,
    input  logic [ARCH_W-1:0] i_disp_dst,
    output logic              o_rat_valid,
    output logic [TAG_W-1:0]  o_rat_rob_addr,
    output logic [ARCH_W-1:0] o_rat_dst_addr,
    input  logic              i_wb_valid,
    input  logic [TAG_W-1:0]  i_wb_tag,
    input  logic [DATA_W-1:0] i_wb_data,
    output logic              o_cmt_valid,
    output logic [TAG_W-1:0]  o_cmt_tag,
    output logic [ARCH_W-1:0] o_cmt_dst,
    output logic [DATA_W-1:0] o_cmt_data,
    output logic [TAG_W:0]    o_count
);
    localparam logic [TAG_W:0] FULL = (TAG_W+1)'(DEPTH);

    logic [DEPTH-1:0]  valid_q, valid_d, done_q, done_d;
    logic [ARCH_W-1:0] dst_q [DEPTH];
    logic [ARCH_W-1:0] dst_d [DEPTH];
    logic [DATA_W-1:0] data_q [DEPTH];
    logic [DATA_W-1:0] data_d [DEPTH];
    logic [TAG_W-1:0]  head_q, head_d, tail_q, tail_d;
    logic [TAG_W:0]    count_q, count_d;
    logic              flush, fire, wb_hit;

`ifdef ROB_FLUSH_EN
    assign flush = i_flush;
`else
    assign flush = 1'b0;
`endif

    // Readiness looks only at registered occupancy, so a full ROB refuses even when the head retires.
    assign o_disp_ready   = (count_q != FULL) & ~flush;
    assign fire           = i_disp_valid & o_disp_ready;
    assign o_rat_valid    = fire;
    assign o_rat_rob_addr = tail_q;
    assign o_rat_dst_addr = i_disp_dst;
    assign o_cmt_valid    = valid_q[head_q] & done_q[head_q] & ~flush;
    assign o_cmt_tag      = head_q;
    assign o_cmt_dst      = dst_q[head_q];
    assign o_cmt_data     = data_q[head_q];
    assign o_count        = count_q;
    assign wb_hit         = i_wb_valid & valid_q[i_wb_tag] & ~flush;

    always_comb begin
        valid_d = valid_q;
        done_d  = done_q;
        dst_d   = dst_q;
        data_d  = data_q;
        head_d  = head_q + TAG_W'(o_cmt_valid);
        tail_d  = tail_q + TAG_W'(fire);
        count_d = count_q + (TAG_W+1)'(fire) - (TAG_W+1)'(o_cmt_valid);
        if (wb_hit) begin
            done_d[i_wb_tag] = 1'b1;
            data_d[i_wb_tag] = i_wb_data;
        end
        if (o_cmt_valid) begin
            valid_d[head_q] = 1'b0;
            done_d[head_q]  = 1'b0;
        end
        if (fire) begin
            valid_d[tail_q] = 1'b1;
            done_d[tail_q]  = 1'b0;
            dst_d[tail_q]   = i_disp_dst;
        end
        if (flush) begin
            valid_d = '0;
            done_d  = '0;
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end
    end

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            valid_q <= '0;
            done_q  <= '0;
            dst_q   <= '{default: '0};
            data_q  <= '{default: '0};
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            valid_q <= valid_d;
            done_q  <= done_d;
            dst_q   <= dst_d;
            data_q  <= data_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end
endmodule

// File: tb/tb_rob_ctrl.sv
// tb_rob_ctrl: randomized bench for rob_ctrl against a program-order queue model,
// plus directed sequences with literal expectations.
module tb_rob_ctrl;
    logic        clk = 1'b0, rstn = 1'b0, flush = 1'b0;
    logic        dv = 1'b0, wv = 1'b0;
    logic [1:0]  dd = '0, wt = '0;
    logic [15:0] wd = '0;
    logic        o_disp_ready, o_rat_valid, o_cmt_valid;
    logic [1:0]  o_rat_rob_addr, o_rat_dst_addr, o_cmt_tag, o_cmt_dst;
    logic [15:0] o_cmt_data;
    logic [2:0]  o_count;
    int          errors = 0, checks = 0;

    typedef struct {
        int          tag;
        logic [1:0]  dst;
        bit          done;
        logic [15:0] data;
    } ent_t;
    ent_t q[$];
    int   ntag = 0;

    always #5 clk = ~clk;

    rob_ctrl dut (
        .i_clk(clk), .i_rstn(rstn),
`ifdef ROB_FLUSH_EN
        .i_flush(flush),
`endif
        .i_disp_valid(dv), .o_disp_ready(o_disp_ready), .i_disp_dst(dd),
        .o_rat_valid(o_rat_valid), .o_rat_rob_addr(o_rat_rob_addr), .o_rat_dst_addr(o_rat_dst_addr),
        .i_wb_valid(wv), .i_wb_tag(wt), .i_wb_data(wd),
        .o_cmt_valid(o_cmt_valid), .o_cmt_tag(o_cmt_tag), .o_cmt_dst(o_cmt_dst),
        .o_cmt_data(o_cmt_data), .o_count(o_count)
    );

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic bit m_ready();
        return q.size() < 4 && !flush;
    endfunction

    function automatic bit m_cmt();
        return !flush && q.size() > 0 && q[0].done;
    endfunction

    // Reference: in-flight instructions held in program order; only the oldest may retire.
    always @(posedge clk or negedge rstn) begin
        if (!rstn || flush) begin
            q.delete();
            ntag = 0;
        end else begin
            bit rdy, cm;
            rdy = m_ready();
            cm  = m_cmt();
            if (wv)
                foreach (q[k])
                    if (q[k].tag == int'(wt)) begin
                        q[k].done = 1'b1;
                        q[k].data = wd;
                    end
            if (cm) void'(q.pop_front());
            if (dv && rdy) begin
                q.push_back('{tag: ntag, dst: dd, done: 1'b0, data: 16'h0});
                ntag = (ntag + 1) % 4;
            end
        end
    end

    always @(negedge clk) begin
        if (rstn) begin
            bit rdy, fire, cm;
            rdy  = m_ready();
            fire = dv && rdy;
            cm   = m_cmt();
            chk("m_disp_ready", int'(o_disp_ready), int'(rdy));
            chk("m_rat_valid", int'(o_rat_valid), int'(fire));
            if (fire) begin
                chk("m_rat_addr", int'(o_rat_rob_addr), ntag);
                chk("m_rat_dst", int'(o_rat_dst_addr), int'(dd));
            end
            chk("m_cmt_valid", int'(o_cmt_valid), int'(cm));
            if (cm) begin
                chk("m_cmt_tag", int'(o_cmt_tag), q[0].tag);
                chk("m_cmt_dst", int'(o_cmt_dst), int'(q[0].dst));
                chk("m_cmt_data", int'(o_cmt_data), int'(q[0].data));
            end
            chk("m_count", int'(o_count), q.size());
        end
    end

    task automatic set_in(input bit v, input int d, input bit w, input int t, input int x);
        dv = v; dd = 2'(d); wv = w; wt = 2'(t); wd = 16'(x);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int dsts[4] = '{2, 1, 3, 0};
        #12;
        chk("rst_count", int'(o_count), 0);
        chk("rst_ready", int'(o_disp_ready), 1);
        chk("rst_cmt", int'(o_cmt_valid), 0);
        chk("rst_rat", int'(o_rat_valid), 0);
        rstn = 1'b1;
        tick();
        for (int i = 0; i < 4; i++) begin
            set_in(1, dsts[i], 0, 0, 0);
            @(negedge clk);
            chk("t2_rat_valid", int'(o_rat_valid), 1);
            chk("t2_rat_addr", int'(o_rat_rob_addr), i);
            tick();
        end
        set_in(0, 0, 1, 1, 16'h0007);
        @(negedge clk);
        chk("t2_count", int'(o_count), 4);
        chk("t2_ready", int'(o_disp_ready), 0);
        tick();
        set_in(0, 0, 1, 0, 16'h0005);
        @(negedge clk);
        chk("t3_no_cmt", int'(o_cmt_valid), 0);
        tick();
        set_in(0, 0, 0, 0, 0);
        @(negedge clk);
        chk("t3_cmt0_v", int'(o_cmt_valid), 1);
        chk("t3_cmt0_tag", int'(o_cmt_tag), 0);
        chk("t3_cmt0_dst", int'(o_cmt_dst), 2);
        chk("t3_cmt0_data", int'(o_cmt_data), 16'h0005);
        tick();
        @(negedge clk);
        chk("t3_cmt1_v", int'(o_cmt_valid), 1);
        chk("t3_cmt1_tag", int'(o_cmt_tag), 1);
        chk("t3_cmt1_dst", int'(o_cmt_dst), 1);
        chk("t3_cmt1_data", int'(o_cmt_data), 16'h0007);
        tick();
        set_in(0, 0, 1, 2, 16'h0022);
        tick();
        set_in(0, 0, 1, 3, 16'h0033);
        tick();
        set_in(0, 0, 0, 0, 0);
        tick();
        for (int i = 0; i < 4; i++) begin
            set_in(1, i, 0, 0, 0);
            tick();
        end
        set_in(0, 0, 1, 0, 16'h0044);
        @(negedge clk);
        chk("t4_full", int'(o_count), 4);
        tick();
        set_in(1, 3, 0, 0, 0);
        @(negedge clk);
        chk("t4_c1_cmt", int'(o_cmt_valid), 1);
        chk("t4_c1_tag", int'(o_cmt_tag), 0);
        chk("t4_c1_rat", int'(o_rat_valid), 0);
        tick();
        @(negedge clk);
        chk("t4_c2_rat", int'(o_rat_valid), 1);
        chk("t4_c2_addr", int'(o_rat_rob_addr), 0);
        tick();
        set_in(0, 0, 0, 0, 0);
        @(negedge clk);
        chk("t4_count", int'(o_count), 4);
        for (int k = 0; k < 4; k++) begin
            set_in(0, 0, 1, (1 + k) % 4, k);
            tick();
        end
        set_in(0, 0, 0, 0, 0);
        tick();
        set_in(0, 0, 1, 2, 16'hBEEF);
        @(negedge clk);
        chk("t5_empty", int'(o_count), 0);
        chk("t5_no_cmt", int'(o_cmt_valid), 0);
        tick();
        set_in(1, 1, 0, 0, 0);
        tick();
        set_in(1, 2, 0, 0, 0);
        @(negedge clk);
        chk("t5_addr2", int'(o_rat_rob_addr), 2);
        tick();
        set_in(0, 0, 1, 1, 16'h0101);
        @(negedge clk);
        chk("t5_wait1", int'(o_cmt_valid), 0);
        tick();
        set_in(0, 0, 0, 0, 0);
        @(negedge clk);
        chk("t5_cmt1", int'(o_cmt_valid), 1);
        tick();
        @(negedge clk);
        chk("t5_hold2", int'(o_cmt_valid), 0);
        tick();
        set_in(0, 0, 1, 2, 16'h0202);
        tick();
        set_in(0, 0, 0, 0, 0);
        @(negedge clk);
        chk("t5_cmt2_v", int'(o_cmt_valid), 1);
        chk("t5_cmt2_data", int'(o_cmt_data), 16'h0202);
        tick();
        for (int i = 0; i < 3; i++) begin
            set_in(1, i, 0, 0, 0);
            tick();
        end
        set_in(0, 0, 0, 0, 0);
        rstn = 1'b0;
        #1;
        chk("t1_count", int'(o_count), 0);
        chk("t1_ready", int'(o_disp_ready), 1);
        chk("t1_cmt", int'(o_cmt_valid), 0);
        chk("t1_rat", int'(o_rat_valid), 0);
        tick();
        rstn = 1'b1;
        tick();
`ifdef ROB_FLUSH_EN
        for (int i = 0; i < 3; i++) begin
            set_in(1, i, 0, 0, 0);
            tick();
        end
        flush = 1'b1;
        set_in(1, 3, 0, 0, 0);
        @(negedge clk);
        chk("t6_rat", int'(o_rat_valid), 0);
        chk("t6_ready", int'(o_disp_ready), 0);
        chk("t6_cmt", int'(o_cmt_valid), 0);
        tick();
        flush = 1'b0;
        @(negedge clk);
        chk("t6_count", int'(o_count), 0);
        chk("t6_addr", int'(o_rat_rob_addr), 0);
        chk("t6_rat_v", int'(o_rat_valid), 1);
        tick();
`endif
        for (int c = 0; c < 2000; c++) begin
            set_in($urandom_range(0, 1) == 1, $urandom_range(0, 3), $urandom_range(0, 1) == 1,
                   $urandom_range(0, 3), $urandom_range(0, 16'hFFFF));
`ifdef ROB_FLUSH_EN
            flush = ($urandom_range(0, 29) == 0);
`endif
            tick();
        end
        set_in(0, 0, 0, 0, 0);
        flush = 1'b0;
        tick();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
